// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer and per-hart flush.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining PIPE_REG_PERF_EN.
module ex_mem_skid_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HART_NUM = 4,
  localparam int unsigned HID_W   = (HART_NUM > 1) ? $clog2(HART_NUM) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [HID_W-1:0]    in_hid,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [HID_W-1:0]    out_hid,
  input  logic [HART_NUM-1:0] flush_mask,
  output logic [1:0]          occupancy
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
`endif
);

  // Flush mask widened to cover every encodable hid so indexing never leaves the vector.
  localparam int unsigned MaskW = 1 << HID_W;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [HID_W-1:0]  main_hid_q, main_hid_d;
  logic [HID_W-1:0]  skid_hid_q, skid_hid_d;

  logic              accept;
  logic              pop;
  logic [MaskW-1:0]  flush_ext;

  // Candidates in FIFO order: 0 = main, 1 = skid, 2 = incoming op.
  logic [2:0]        cand_v;
  logic [2:0]        cand_keep;
  logic [2:0]        cand_kill;
  logic [DATA_W-1:0] cand_data [3];
  logic [HID_W-1:0]  cand_hid  [3];
  logic [1:0]        keep_cnt;
  logic [1:0]        flush_inc;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    flush_ext                 = '0;
    flush_ext[HART_NUM-1:0]   = flush_mask;
  end

  // Entries that still exist after this cycle's handshakes, then filtered by flush.
  always_comb begin
    cand_v[0]    = (state_q != StEmpty) & ~pop;
    cand_v[1]    = (state_q == StFull);
    cand_v[2]    = accept;
    cand_data[0] = main_data_q;
    cand_data[1] = skid_data_q;
    cand_data[2] = in_data;
    cand_hid[0]  = main_hid_q;
    cand_hid[1]  = skid_hid_q;
    cand_hid[2]  = (HART_NUM > 1) ? in_hid : '0;
    cand_keep    = '0;
    cand_kill    = '0;
    for (int i = 0; i < 3; i++) begin
      cand_kill[i] = cand_v[i] & flush_ext[cand_hid[i]];
      cand_keep[i] = cand_v[i] & ~flush_ext[cand_hid[i]];
    end
    flush_inc = 2'(cand_kill[0]) + 2'(cand_kill[1]) + 2'(cand_kill[2]);
  end

  // Next state: compact the surviving candidates into main/skid, preserving order.
  always_comb begin
    main_data_d = '0;
    main_hid_d  = '0;
    skid_data_d = '0;
    skid_hid_d  = '0;
    keep_cnt    = '0;
    for (int i = 0; i < 3; i++) begin
      if (cand_keep[i]) begin
        if (keep_cnt == 2'd0) begin
          main_data_d = cand_data[i];
          main_hid_d  = cand_hid[i];
        end else begin
          skid_data_d = cand_data[i];
          skid_hid_d  = cand_hid[i];
        end
        keep_cnt = keep_cnt + 2'd1;
      end
    end
    case (keep_cnt)
      2'd0:    state_d = StEmpty;
      2'd1:    state_d = StOne;
      default: state_d = StFull;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_hid_q  <= '0;
      skid_data_q <= '0;
      skid_hid_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_hid_q  <= main_hid_d;
      skid_data_q <= skid_data_d;
      skid_hid_q  <= skid_hid_d;
    end
  end

  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    out_data  = main_data_q;
    out_hid   = main_hid_q;
    case (state_q)
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef PIPE_REG_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid & ~out_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      flush_cnt <= flush_cnt + 32'(flush_inc);
    end
  end
`else
  logic unused_flush_inc;
  assign unused_flush_inc = ^flush_inc;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Randomised bench for ex_mem_skid_reg against a queue-based reference model,
// plus directed scenarios and a HART_NUM=1 / DATA_W=64 instance.
module tb_ex_mem_skid_reg;

  localparam int DW = 32;
  localparam int HN = 4;
  localparam int HW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [HW-1:0] in_hid = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [HW-1:0] out_hid;
  logic [HN-1:0] flush_mask = '0;
  logic [1:0]    occupancy;
`ifdef PIPE_REG_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt;
  logic [31:0]   b_stall_cnt, b_flush_cnt;
`endif

  ex_mem_skid_reg #(.DATA_W(DW), .HART_NUM(HN)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_hid     (in_hid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_hid    (out_hid),
    .flush_mask (flush_mask),
    .occupancy  (occupancy)
`ifdef PIPE_REG_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  // Second instance: single hart, 64-bit payload.
  logic        b_reset = 1'b1;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [63:0] b_in_data = '0;
  logic [0:0]  b_in_hid = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [63:0] b_out_data;
  logic [0:0]  b_out_hid;
  logic [0:0]  b_flush_mask = '0;
  logic [1:0]  b_occupancy;
  bit          b_done = 1'b0;

  ex_mem_skid_reg #(.DATA_W(64), .HART_NUM(1)) dut_b (
    .clk        (clk),
    .reset      (b_reset),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .in_hid     (b_in_hid),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_data   (b_out_data),
    .out_hid    (b_out_hid),
    .flush_mask (b_flush_mask),
    .occupancy  (b_occupancy)
`ifdef PIPE_REG_PERF_EN
    ,
    .stall_cnt  (b_stall_cnt),
    .flush_cnt  (b_flush_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [HW-1:0] h;
  } op_t;

  op_t         mq[$];
  int unsigned m_stall;
  int unsigned m_flush;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [DW-1:0] ed;
    logic [HW-1:0] eh;
    ed = '0;
    eh = '0;
    if (mq.size() > 0) begin
      ed = mq[0].d;
      eh = mq[0].h;
    end
    check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check_eq("out_data", 64'(out_data), 64'(ed));
    check_eq("out_hid", 64'(out_hid), 64'(eh));
    check_eq("occupancy", 64'(occupancy), 64'(mq.size()));
    check_eq("in_ready", 64'(in_ready), 64'(mq.size() < 2));
`ifdef PIPE_REG_PERF_EN
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check_eq("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // Check current outputs, drive one cycle of inputs, advance the model past the next edge.
  task automatic step(input logic rst, input logic iv, input logic [DW-1:0] d,
                      input logic [HW-1:0] h, input logic ordy, input logic [HN-1:0] fm);
    bit  acc;
    op_t keep[$];
    @(negedge clk);
    check_model();
    reset      = rst;
    in_valid   = iv;
    in_data    = d;
    in_hid     = h;
    out_ready  = ordy;
    flush_mask = fm;
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      acc = iv && (mq.size() < 2);
      if (mq.size() > 0 && !ordy) m_stall++;
      if (ordy && mq.size() > 0) void'(mq.pop_front());
      if (acc) mq.push_back(op_t'({d, h}));
      foreach (mq[i]) begin
        if (fm[mq[i].h]) m_flush++;
        else keep.push_back(mq[i]);
      end
      mq = keep;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mq.delete();
    m_stall = 0;
    m_flush = 0;
    step(1, 0, '0, '0, 0, '0);
    step(1, 0, '0, '0, 0, '0);

    // Single op then 8 back-to-back ops at full rate.
    step(0, 1, 32'hA5, 2'd1, 1, '0);
    after_edge();
    check_eq("s1_valid", 64'(out_valid), 64'd1);
    check_eq("s1_data", 64'(out_data), 64'hA5);
    check_eq("s1_hid", 64'(out_hid), 64'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 32'(32'h100 + i), 2'(i), 1, '0);
      after_edge();
      check_eq("s1_stream", 64'(out_data), 64'(32'h100 + i));
    end
    step(0, 0, '0, '0, 1, '0);

    // Back-pressure fills the skid, then drains in order.
    step(0, 1, 32'h11, 2'd0, 0, '0);
    step(0, 1, 32'h22, 2'd0, 0, '0);
    step(0, 1, 32'h33, 2'd0, 0, '0);
    after_edge();
    check_eq("s2_occ", 64'(occupancy), 64'd2);
    check_eq("s2_ready", 64'(in_ready), 64'd0);
    check_eq("s2_head", 64'(out_data), 64'h11);
    step(0, 1, 32'h33, 2'd0, 1, '0);
    after_edge();
    check_eq("s2_pop1", 64'(out_data), 64'h22);
    step(0, 1, 32'h33, 2'd0, 1, '0);
    after_edge();
    check_eq("s2_pop2", 64'(out_data), 64'h33);
    step(0, 0, '0, '0, 1, '0);
    after_edge();
    check_eq("s2_empty", 64'(out_valid), 64'd0);

    // Flush the main entry's hart; skid moves up.
    step(0, 1, 32'hC0, 2'd0, 0, '0);
    step(0, 1, 32'hC2, 2'd2, 0, '0);
    step(0, 0, '0, '0, 0, 4'b0001);
    after_edge();
    check_eq("s3_data", 64'(out_data), 64'hC2);
    check_eq("s3_hid", 64'(out_hid), 64'd2);
    check_eq("s3_occ", 64'(occupancy), 64'd1);
    step(0, 0, '0, '0, 1, '0);

    // Incoming op flushed in its accept cycle.
    step(0, 1, 32'h77, 2'd3, 1, 4'b1000);
    after_edge();
    check_eq("s4_valid", 64'(out_valid), 64'd0);

    // Stall while full, then reset.
    step(0, 1, 32'h55, 2'd1, 0, '0);
    step(0, 1, 32'h66, 2'd2, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, '0, '0, 0, '0);
    step(1, 0, '0, '0, 0, '0);
    after_edge();
    check_eq("s5_valid", 64'(out_valid), 64'd0);
    check_eq("s5_data", 64'(out_data), 64'd0);
    check_eq("s5_occ", 64'(occupancy), 64'd0);
    check_eq("s5_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_REG_PERF_EN
    check_eq("s5_stall", 64'(stall_cnt), 64'd0);
`endif
    step(0, 0, '0, '0, 0, '0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [HN-1:0] fm;
      fm = ($urandom_range(0, 5) == 0) ? HN'($urandom_range(1, 15)) : '0;
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), $urandom,
           HW'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), fm);
    end
    step(0, 0, '0, '0, 1, '0);

    check_eq("b_done", 64'(b_done), 64'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    b_in_valid = 1'b1;
    b_in_data = 64'hA5A5_0000_0000_00A5;
    b_out_ready = 1'b1;
    after_edge();
    check_eq("b1_valid", 64'(b_out_valid), 64'd1);
    check_eq("b1_data", b_out_data, 64'hA5A5_0000_0000_00A5);
    check_eq("b1_hid", 64'(b_out_hid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_in_data = {32'(32'hDEAD_0000 + i), 32'(i)};
      after_edge();
      check_eq("b1_stream", b_out_data, {32'(32'hDEAD_0000 + i), 32'(i)});
      check_eq("b1_ready", 64'(b_in_ready), 64'd1);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    after_edge();
    check_eq("b1_empty", 64'(b_out_valid), 64'd0);
    check_eq("b1_zero", b_out_data, 64'd0);

    @(negedge clk);
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_in_data = 64'h1111_1111_1111_1111;
    after_edge();
    check_eq("b2_occ1", 64'(b_occupancy), 64'd1);
    @(negedge clk);
    b_in_data = 64'h2222_2222_2222_2222;
    after_edge();
    check_eq("b2_occ2", 64'(b_occupancy), 64'd2);
    check_eq("b2_ready", 64'(b_in_ready), 64'd0);
    @(negedge clk);
    b_in_data = 64'h3333_3333_3333_3333;
    after_edge();
    check_eq("b2_held", b_out_data, 64'h1111_1111_1111_1111);
    @(negedge clk);
    b_out_ready = 1'b1;
    after_edge();
    check_eq("b2_pop1", b_out_data, 64'h2222_2222_2222_2222);
    after_edge();
    check_eq("b2_pop2", b_out_data, 64'h3333_3333_3333_3333);
    check_eq("b2_hid", 64'(b_out_hid), 64'd0);
    @(negedge clk);
    b_in_valid = 1'b0;
    after_edge();
    check_eq("b2_empty", 64'(b_out_valid), 64'd0);
    check_eq("b2_occ0", 64'(b_occupancy), 64'd0);
    b_done = 1'b1;
  end

endmodule
